// File: rtl/aes_ctr_stream.sv
// ---------------------------------------------------------------------------
// aes_ctr_stream -- AES-128 counter-mode streaming engine
//
// Holds a key and a 128-bit counter block. It XORs each input block with
// AES(key, counter) and accepts up to one block per clock. Input and output
// use valid/ready handshakes with full backpressure.
//
// Pipeline:  accept -> S1 {data, ctr, last} -> aes_comb -> S2 (output reg)
// A block accepted at edge k is presented on out_* after edge k+1.
//
// Session FSM: IDLE -> RUN on cfg_load. RUN -> DRAIN on an accepted in_last
// (when LAST_ENDS_SESSION=1). RUN -> LOCK when the counter field is
// exhausted. DRAIN -> IDLE once the pipe is empty. LOCK -> RUN on cfg_load
// with an empty pipe.
//
// Parameters:
//   CTR_WIDTH          low-order counter bits that increment (8..128)
//   LAST_ENDS_SESSION  1: accepted in_last ends the session; 0: tag only
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_load/key/iv       session load (honoured in IDLE, or LOCK with empty pipe)
//   in_valid/ready/data/last    input stream
//   out_valid/ready/data/last   output stream
//   busy                  state != IDLE or any stage occupied
//   ctr_wrap              sticky counter-exhaustion flag, cleared by cfg_load
//
// Optional macro AES_CTR_BYTE_MASK_EN adds in_keep/out_keep (bit i qualifies
// byte i, byte 0 = bits 127:120). Bytes with keep=0 are forced to zero.
// ---------------------------------------------------------------------------

// Combinational AES-128 encryption core. It performs the full key expansion
// and all ten rounds in one cycle.
module aes_comb (
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic [127:0] ciphertext
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // S-box is computed rather than tabulated. The inverse is x^254 in
  // GF(2^8) (0 maps to 0), and the standard affine transform follows.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, xp, inv;
    x2  = gf_mul(x, x);
    x3  = gf_mul(x2, x);
    x6  = gf_mul(x3, x3);
    x12 = gf_mul(x6, x6);
    x15 = gf_mul(x12, x3);
    xp  = x15;
    for (int i = 0; i < 4; i++) xp = gf_mul(xp, xp);  // x^240
    inv = gf_mul(gf_mul(xp, x12), x2);                 // x^254
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Byte idx of the block sits at bits [127-8*idx -: 8]; idx = col*4 + row.
  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return r;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(c*4+w) -: 8] = s[127-8*(((c+w)%4)*4+w) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt,
                                               input logic [127:0] k0);
    logic [127:0] st, rk;
    logic [31:0]  t, w0, w1, w2, w3;
    logic [7:0]   rcon;
    rk   = k0;
    st   = pt ^ k0;
    rcon = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      // Round key r is derived from round key r-1 on the fly.
      t  = sub_word({rk[23:0], rk[31:24]}) ^ {rcon, 24'h0};
      w0 = rk[127:96] ^ t;
      w1 = rk[95:64]  ^ w0;
      w2 = rk[63:32]  ^ w1;
      w3 = rk[31:0]   ^ w2;
      rk = {w0, w1, w2, w3};
      rcon = xtime(rcon);
      st = shift_rows(sub_bytes(st));
      if (r < 10) st = mix_columns(st);
      st = st ^ rk;
    end
    return st;
  endfunction

  assign ciphertext = aes_encrypt(plaintext, key);

endmodule

module aes_ctr_stream #(
  parameter int CTR_WIDTH         = 32,
  parameter bit LAST_ENDS_SESSION = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_load,
  input  logic [127:0] cfg_key,
  input  logic [127:0] cfg_iv,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_last,
`ifdef AES_CTR_BYTE_MASK_EN
  input  logic [15:0]  in_keep,
  output logic [15:0]  out_keep,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_last,
  output logic         busy,
  output logic         ctr_wrap
);

  if (CTR_WIDTH < 8 || CTR_WIDTH > 128) begin : g_bad_ctr_width
    $error("aes_ctr_stream: CTR_WIDTH must be in 8..128");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_LOCK} state_e;

  // Selects the incrementing field. When CTR_WIDTH=128 the shift yields 0,
  // and 0 - 1 gives the full-width mask.
  localparam logic [127:0] CTR_MASK = (128'd1 << CTR_WIDTH) - 128'd1;

  state_e       state, state_d;
  logic [127:0] key_reg, ctr_reg, ctr_inc;
  logic         s1_valid, s1_last;
  logic [127:0] s1_data, s1_ctr;
  logic [127:0] keystream, s2_data_d;
  logic         s2_load, s1_advance, accept, pipe_empty, ctr_at_max, load_ok;

  // S2 can take a new value when it is empty or being drained this edge.
  assign s2_load    = !out_valid || out_ready;
  assign s1_advance = s1_valid && s2_load;
  assign in_ready   = (state == ST_RUN) && (!s1_valid || s2_load);
  assign accept     = in_valid && in_ready;
  assign pipe_empty = !s1_valid && !out_valid;
  assign ctr_at_max = (ctr_reg & CTR_MASK) == CTR_MASK;
  assign ctr_inc    = (ctr_reg & ~CTR_MASK) | ((ctr_reg + 128'd1) & CTR_MASK);
  assign busy       = (state != ST_IDLE) || !pipe_empty;

  // A reload is only allowed when no block can observe the key change.
  assign load_ok = cfg_load &&
                   ((state == ST_IDLE) || (state == ST_LOCK && pipe_empty));

  aes_comb u_core (
    .plaintext  (s1_ctr),
    .key        (key_reg),
    .ciphertext (keystream)
  );

`ifdef AES_CTR_BYTE_MASK_EN
  logic [15:0]  s1_keep;
  logic [127:0] keep_mask;

  always_comb begin
    keep_mask = '0;
    for (int i = 0; i < 16; i++) keep_mask[127-8*i -: 8] = {8{s1_keep[i]}};
  end

  assign s2_data_d = (s1_data ^ keystream) & keep_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_keep  <= '0;
      out_keep <= '0;
    end else begin
      if (accept)                s1_keep  <= in_keep;
      if (s2_load && s1_valid)   out_keep <= s1_keep;
    end
  end
`else
  assign s2_data_d = s1_data ^ keystream;
`endif

  // NOTE: every output of an always_comb block is given a default first, so
  // no path through the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:  if (cfg_load) state_d = ST_RUN;
      ST_RUN: begin
        // Exhaustion takes priority over in_last on the same block.
        if (accept && ctr_at_max)                        state_d = ST_LOCK;
        else if (accept && in_last && LAST_ENDS_SESSION) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (pipe_empty)             state_d = ST_IDLE;
      ST_LOCK:  if (cfg_load && pipe_empty) state_d = ST_RUN;
      default:                              state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values and the stage-to-stage hand-off stays
  // order-independent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      key_reg   <= '0;
      ctr_reg   <= '0;
      ctr_wrap  <= 1'b0;
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_ctr    <= '0;
      s1_last   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      state <= state_d;

      if (load_ok) begin
        key_reg  <= cfg_key;
        ctr_reg  <= cfg_iv;
        ctr_wrap <= 1'b0;
      end else if (accept) begin
        ctr_reg <= ctr_inc;
        if (ctr_at_max) ctr_wrap <= 1'b1;
      end

      if (accept) begin
        s1_valid <= 1'b1;
        s1_data  <= in_data;
        s1_ctr   <= ctr_reg;
        s1_last  <= in_last;
      end else if (s1_advance) begin
        s1_valid <= 1'b0;
      end

      // Data is held while stalled or idle; only the valid bit follows S1.
      if (s2_load) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= s2_data_d;
          out_last <= s1_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_ctr_stream.sv
// ---------------------------------------------------------------------------
// tb_aes_ctr_stream -- directed self-checking bench for aes_ctr_stream.
// u_dut uses the default 32-bit counter field. u_wrap uses an 8-bit field
// to reach counter exhaustion quickly. Expected values are the published
// FIPS-197 and SP800-38A F.5.1 vectors.
// ---------------------------------------------------------------------------
module tb_aes_ctr_stream;

  localparam logic [127:0] K_FIPS  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] IV_FIPS = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_FIPS  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K_SP    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV_SP   = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] IV_FE   = 128'h00112233445566778899aabbccddeefe;

  logic clk, rst_n;

  logic         cfg_load, in_valid, in_ready, in_last, out_valid, out_ready;
  logic         out_last, busy, ctr_wrap;
  logic [127:0] cfg_key, cfg_iv, in_data, out_data;

  logic         w_cfg_load, w_in_valid, w_in_ready, w_in_last, w_out_valid;
  logic         w_out_ready, w_out_last, w_busy, w_ctr_wrap;
  logic [127:0] w_cfg_key, w_cfg_iv, w_in_data, w_out_data;

`ifdef AES_CTR_BYTE_MASK_EN
  logic [15:0] in_keep, out_keep, w_in_keep, w_out_keep;
  assign in_keep   = 16'hffff;
  assign w_in_keep = 16'hffff;
`endif

  logic [127:0] pt [4];
  logic [127:0] ct [4];
  int pass_cnt, fail_cnt, total_cnt;
  int sent, got, n_acc, n_out;

  aes_ctr_stream u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_key(cfg_key),
    .cfg_iv(cfg_iv), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last),
`ifdef AES_CTR_BYTE_MASK_EN
    .in_keep(in_keep), .out_keep(out_keep),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .ctr_wrap(ctr_wrap)
  );

  aes_ctr_stream #(.CTR_WIDTH(8)) u_wrap (
    .clk(clk), .rst_n(rst_n), .cfg_load(w_cfg_load), .cfg_key(w_cfg_key),
    .cfg_iv(w_cfg_iv), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_data(w_in_data), .in_last(w_in_last),
`ifdef AES_CTR_BYTE_MASK_EN
    .in_keep(w_in_keep), .out_keep(w_out_keep),
`endif
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
    .out_last(w_out_last), .busy(w_busy), .ctr_wrap(w_ctr_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled at negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    check(tag, busy, 1'b0);
  endtask

  task automatic load_main(input logic [127:0] k, input logic [127:0] iv);
    cfg_key = k; cfg_iv = iv; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  initial begin
    pass_cnt = 0; fail_cnt = 0; total_cnt = 0;
    pt[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
    pt[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    pt[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    pt[3] = 128'hf69f2445df4f9b17ad2b417be66c3710;
    ct[0] = 128'h874d6191b620e3261bef6864990db6ce;
    ct[1] = 128'h9806f66b7970fdff8617187bb9fffdff;
    ct[2] = 128'h5ae4df3edbd5d35e5b4f09020db03eab;
    ct[3] = 128'h1e031dda2fbe03d1792170a0f3009cee;

    rst_n = 1'b0;
    cfg_load = 0; cfg_key = '0; cfg_iv = '0; in_valid = 0; in_data = '0;
    in_last = 0; out_ready = 0;
    w_cfg_load = 0; w_cfg_key = '0; w_cfg_iv = '0; w_in_valid = 0;
    w_in_data = '0; w_in_last = 0; w_out_ready = 0;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_ctr_wrap", ctr_wrap, 1'b0);
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", in_ready, 1'b0);

    // 1. FIPS-197 keystream, single block with in_last
    load_main(K_FIPS, IV_FIPS);
    check("fips_in_ready", in_ready, 1'b1);
    in_valid = 1; in_data = '0; in_last = 1; out_ready = 1;
    tick();
    in_valid = 0; in_last = 0;
    check("fips_latency_s1", out_valid, 1'b0);
    tick();
    check("fips_out_valid", out_valid, 1'b1);
    check("fips_out_data", out_data, C_FIPS);
    check("fips_out_last", out_last, 1'b1);
    check("fips_drain_ready", in_ready, 1'b0);
    wait_idle("fips_idle");

    // 2 + 5. SP800-38A back-to-back, ignored mid-RUN reload, session end
    load_main(K_SP, IV_SP);
    in_valid = 1; in_data = pt[0];
    tick();
    in_data = pt[1];
    tick();
    in_valid = 0;
    check("sp_b1_valid", out_valid, 1'b1);
    check("sp_b1_data", out_data, ct[0]);
    tick();
    check("sp_b2_data", out_data, ct[1]);
    cfg_key = K_FIPS; cfg_iv = IV_FIPS; cfg_load = 1;
    tick();
    cfg_load = 0;
    check("sp_drained", out_valid, 1'b0);
    check("sp_run_ready", in_ready, 1'b1);
    in_valid = 1; in_data = pt[2]; in_last = 1;
    tick();
    in_valid = 0; in_last = 0;
    tick();
    check("sess_b3_data", out_data, ct[2]);
    check("sess_b3_last", out_last, 1'b1);
    wait_idle("sess_idle");
    check("sess_in_ready", in_ready, 1'b0);
    check("sess_no_wrap", ctr_wrap, 1'b0);

    // 3. Backpressure: out_ready low for 5 cycles of a 4-block burst
    load_main(K_SP, IV_SP);
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      out_ready = (cyc >= 5);
      if (sent < 4) begin
        in_valid = 1; in_data = pt[sent]; in_last = (sent == 3);
      end else begin
        in_valid = 0; in_last = 0;
      end
      #1;
      if (cyc == 2) begin
        check("bp_ready_drop", in_ready, 1'b0);
        check("bp_held_count", 32'(sent), 32'd2);
      end
      if (cyc >= 2 && cyc < 5) check("bp_stall_hold", out_data, ct[0]);
      if (out_valid && out_ready) begin
        check("bp_order", out_data, ct[got]);
        if (got == 3) check("bp_last", out_last, 1'b1);
        got++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 0; in_last = 0;
    check("bp_got_all", 32'(got), 32'd4);
    check("bp_sent_all", 32'(sent), 32'd4);
    check("bp_no_dup", out_valid, 1'b0);
    wait_idle("bp_idle");

    // 4. Counter exhaustion on the 8-bit-field instance
    w_cfg_key = K_FIPS; w_cfg_iv = IV_FE; w_cfg_load = 1;
    tick();
    w_cfg_load = 0;
    w_out_ready = 1; w_in_data = '0; w_in_valid = 1;
    n_acc = 0; n_out = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      #1;
      if (w_in_valid && w_in_ready) n_acc++;
      if (w_out_valid) n_out++;
      tick();
    end
    w_in_valid = 0;
    check("wrap_accepts", 32'(n_acc), 32'd2);
    check("wrap_outputs", 32'(n_out), 32'd2);
    check("wrap_flag", w_ctr_wrap, 1'b1);
    check("wrap_lock_ready", w_in_ready, 1'b0);
    check("wrap_lock_busy", w_busy, 1'b1);
    w_cfg_load = 1;
    tick();
    w_cfg_load = 0;
    check("wrap_reload_clear", w_ctr_wrap, 1'b0);
    check("wrap_reload_ready", w_in_ready, 1'b1);
    w_in_valid = 1;
    tick();
    check("wrap_fe_no_flag", w_ctr_wrap, 1'b0);
    tick();
    w_in_valid = 0;
    check("wrap_ff_flag", w_ctr_wrap, 1'b1);
    check("wrap_ff_ready", w_in_ready, 1'b0);
    tick(); tick(); tick();
    check("wrap_drained", w_out_valid, 1'b0);
    // Reload out of LOCK with a new key; the iv starts at the last value
    w_cfg_key = K_SP; w_cfg_iv = IV_SP; w_cfg_load = 1;
    tick();
    w_cfg_load = 0;
    check("wrap_sp_clear", w_ctr_wrap, 1'b0);
    w_in_valid = 1; w_in_data = pt[0];
    tick();
    w_in_valid = 0;
    tick();
    check("wrap_sp_data", w_out_data, ct[0]);
    check("wrap_sp_last", w_out_last, 1'b0);
    check("wrap_sp_flag", w_ctr_wrap, 1'b1);

    // 6. Asynchronous reset with two blocks in flight
    load_main(K_SP, IV_SP);
    out_ready = 0;
    in_valid = 1; in_data = pt[0];
    tick();
    in_data = pt[1];
    tick();
    in_valid = 0;
    check("inflight_busy", busy, 1'b1);
    check("inflight_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_in_ready", in_ready, 1'b0);
    check("arst_out_data", out_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_valid", out_valid, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
